// File: rtl/ch77_alarm_box.sv
// rtl/ch77_alarm_box.sv - channel 77 alarm latch with monitor-bus readout (optional scaler alarms: CH77_SCALER_ALARMS_EN)
module ch77_alarm_box (
  input  logic SIM_RST,
  input  logic SIM_CLK,
  input  logic p4VSW,
  input  logic GND,
  output logic MDT01,
  input  logic MT01,
  output logic MDT02,
  input  logic MT05,
  output logic MDT03,
  input  logic MT12,
  output logic MDT04,
  input  logic MWL01,
  output logic MDT05,
  input  logic MWL02,
  output logic MDT06,
  input  logic MWL03,
  output logic MDT07,
  input  logic MWL04,
  output logic MDT08,
  input  logic MWL05,
  output logic MDT09,
  input  logic MWL06,
  output logic MDT10,
  input  logic MRCH,
  output logic MDT11,
  input  logic MWCH,
  output logic MDT12,
  input  logic MWSG,
  output logic MDT13,
  input  logic MPAL_n,
  output logic MDT14,
  input  logic MTCAL_n,
  output logic MDT15,
  input  logic MRPTAL_n,
  output logic MDT16,
  input  logic MWATCH_n,
  output logic MNHSBF,
  input  logic MVFAIL_n,
  output logic MNHNC,
  input  logic MCTRAL_n,
  output logic MNHRPT,
  input  logic MSCAFL_n,
  output logic MTCSAI,
  input  logic MSCDBL_n,
  output logic MSTRT,
  output logic MAMU,
  output logic MSTP,
  output logic MSBSTP,
  output logic MRDCH,
  output logic MLDCH,
  output logic MONPAR,
  output logic MONWBK,
  output logic MLOAD,
  output logic MREAD,
  output logic NHALGA,
  output logic DOSCAL,
  output logic DBLTST
);

  localparam logic [5:0] ALARM_CHAN = 6'o77;

  logic [5:0] chan_addr;
  logic [9:1] alarm_latch;
  logic [9:1] alarm_set;
  logic       sel;
  logic       alarm_clr;
  logic       read_en;
  logic       unused_inputs;

  assign sel       = (chan_addr == ALARM_CHAN);
  assign alarm_clr = sel && MWCH && MT05;
  assign read_en   = p4VSW && sel && MRCH;

  // Decode the active-low alarm inputs into per-bit set requests
  always_comb begin
    alarm_set    = '0;
    alarm_set[1] = ~MPAL_n;
    alarm_set[2] = 1'b0;
    alarm_set[3] = ~MTCAL_n;
    alarm_set[4] = ~MRPTAL_n;
    alarm_set[5] = ~MWATCH_n;
    alarm_set[6] = ~MVFAIL_n;
    alarm_set[7] = ~MCTRAL_n;
`ifdef CH77_SCALER_ALARMS_EN
    alarm_set[8] = ~MSCAFL_n;
    alarm_set[9] = ~MSCDBL_n;
`else
    alarm_set[8] = 1'b0;
    alarm_set[9] = 1'b0;
`endif
  end

`ifdef CH77_SCALER_ALARMS_EN
  assign unused_inputs = &{1'b0, GND};
`else
  assign unused_inputs = &{1'b0, GND, MSCAFL_n, MSCDBL_n};
`endif

  // Channel address: loaded from the write bus on WSG+T01, dropped on T12 when not writing
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      chan_addr <= '0;
    end else if (!p4VSW) begin
      chan_addr <= '0;
    end else if (MWSG && MT01) begin
      chan_addr <= {MWL06, MWL05, MWL04, MWL03, MWL02, MWL01};
    end else if (MT12 && !MWSG) begin
      chan_addr <= '0;
    end
  end

  // Alarm latch: a write to channel 77 clears it, but a still-asserted alarm re-sets its bit
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      alarm_latch <= '0;
    end else if (!p4VSW) begin
      alarm_latch <= '0;
    end else begin
      alarm_latch <= (alarm_clr ? 9'b0 : alarm_latch) | alarm_set;
    end
  end

  // Read path is combinational so the latch appears on the bus in the same cycle as RCH
  assign MDT01 = read_en & alarm_latch[1];
  assign MDT02 = read_en & alarm_latch[2];
  assign MDT03 = read_en & alarm_latch[3];
  assign MDT04 = read_en & alarm_latch[4];
  assign MDT05 = read_en & alarm_latch[5];
  assign MDT06 = read_en & alarm_latch[6];
  assign MDT07 = read_en & alarm_latch[7];
  assign MDT08 = read_en & alarm_latch[8];
  assign MDT09 = read_en & alarm_latch[9];
  assign MDT10 = 1'b0;
  assign MDT11 = 1'b0;
  assign MDT12 = 1'b0;
  assign MDT13 = 1'b0;
  assign MDT14 = 1'b0;
  assign MDT15 = 1'b0;
  assign MDT16 = 1'b0;

  // The monitor control lines are never driven by this box
  assign MNHSBF = 1'b0;
  assign MNHNC  = 1'b0;
  assign MNHRPT = 1'b0;
  assign MTCSAI = 1'b0;
  assign MSTRT  = 1'b0;
  assign MAMU   = 1'b0;
  assign MSTP   = 1'b0;
  assign MSBSTP = 1'b0;
  assign MRDCH  = 1'b0;
  assign MLDCH  = 1'b0;
  assign MONPAR = 1'b0;
  assign MONWBK = 1'b0;
  assign MLOAD  = 1'b0;
  assign MREAD  = 1'b0;
  assign NHALGA = 1'b0;
  assign DOSCAL = 1'b0;
  assign DBLTST = 1'b0;

endmodule

// File: tb/tb_ch77_alarm_box.sv
// tb/tb_ch77_alarm_box.sv - randomized model-checked bench for ch77_alarm_box
module tb_ch77_alarm_box;

  logic SIM_RST, SIM_CLK, p4VSW, GND;
  logic MT01, MT05, MT12, MRCH, MWCH, MWSG;
  logic [5:0] wl;
  logic MPAL_n, MTCAL_n, MRPTAL_n, MWATCH_n, MVFAIL_n, MCTRAL_n, MSCAFL_n, MSCDBL_n;
  logic [16:1] mdt;
  logic [16:0] misc;

  int passed = 0;
  int total  = 0;

  // behavioural model state
  int m_chan;
  bit m_alarm[1:9];

  ch77_alarm_box dut (
    .SIM_RST(SIM_RST), .SIM_CLK(SIM_CLK), .p4VSW(p4VSW), .GND(GND),
    .MDT01(mdt[1]), .MT01(MT01), .MDT02(mdt[2]), .MT05(MT05), .MDT03(mdt[3]), .MT12(MT12),
    .MDT04(mdt[4]), .MWL01(wl[0]), .MDT05(mdt[5]), .MWL02(wl[1]), .MDT06(mdt[6]), .MWL03(wl[2]),
    .MDT07(mdt[7]), .MWL04(wl[3]), .MDT08(mdt[8]), .MWL05(wl[4]), .MDT09(mdt[9]), .MWL06(wl[5]),
    .MDT10(mdt[10]), .MRCH(MRCH), .MDT11(mdt[11]), .MWCH(MWCH), .MDT12(mdt[12]), .MWSG(MWSG),
    .MDT13(mdt[13]), .MPAL_n(MPAL_n), .MDT14(mdt[14]), .MTCAL_n(MTCAL_n),
    .MDT15(mdt[15]), .MRPTAL_n(MRPTAL_n), .MDT16(mdt[16]), .MWATCH_n(MWATCH_n),
    .MNHSBF(misc[0]), .MVFAIL_n(MVFAIL_n), .MNHNC(misc[1]), .MCTRAL_n(MCTRAL_n),
    .MNHRPT(misc[2]), .MSCAFL_n(MSCAFL_n), .MTCSAI(misc[3]), .MSCDBL_n(MSCDBL_n),
    .MSTRT(misc[4]), .MAMU(misc[5]), .MSTP(misc[6]), .MSBSTP(misc[7]), .MRDCH(misc[8]),
    .MLDCH(misc[9]), .MONPAR(misc[10]), .MONWBK(misc[11]), .MLOAD(misc[12]), .MREAD(misc[13]),
    .NHALGA(misc[14]), .DOSCAL(misc[15]), .DBLTST(misc[16])
  );

  initial SIM_CLK = 1'b0;
  always #5 SIM_CLK = ~SIM_CLK;

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Expected monitor bus: latch visible only when powered, out of reset, channel 77 and RCH
  function automatic logic [16:1] model_mdt();
    logic [16:1] r;
    r = '0;
    if (p4VSW === 1'b1 && SIM_RST === 1'b1 && m_chan == 63 && MRCH === 1'b1)
      for (int i = 1; i <= 9; i++) r[i] = m_alarm[i];
    return r;
  endfunction

  function automatic bit scaler_en();
`ifdef CH77_SCALER_ALARMS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_clear();
    m_chan = 0;
    for (int i = 1; i <= 9; i++) m_alarm[i] = 1'b0;
  endtask

  // One clock: check outputs mid-low-phase, predict next state, advance to the next falling edge
  task automatic step();
    int  n_chan;
    bit  n_alarm[1:9];
    bit  req[1:9];
    bit  wipe;
    if (!SIM_RST) model_clear();
    #1;
    check("mdt", {1'b0, mdt}, {1'b0, model_mdt()});
    check("misc", misc, 17'h0);
    n_chan = m_chan;
    for (int i = 1; i <= 9; i++) n_alarm[i] = m_alarm[i];
    if (SIM_RST && !p4VSW) begin
      n_chan = 0;
      for (int i = 1; i <= 9; i++) n_alarm[i] = 1'b0;
    end else if (SIM_RST) begin
      if (MWSG && MT01) n_chan = int'(wl);
      else if (MT12 && !MWSG) n_chan = 0;
      req[1] = !MPAL_n;  req[2] = 1'b0;       req[3] = !MTCAL_n;
      req[4] = !MRPTAL_n; req[5] = !MWATCH_n; req[6] = !MVFAIL_n;
      req[7] = !MCTRAL_n; req[8] = scaler_en() && !MSCAFL_n; req[9] = scaler_en() && !MSCDBL_n;
      wipe = (m_chan == 63) && MWCH && MT05;
      for (int i = 1; i <= 9; i++) n_alarm[i] = (wipe ? 1'b0 : m_alarm[i]) | req[i];
    end
    @(posedge SIM_CLK);
    m_chan = n_chan;
    for (int i = 1; i <= 9; i++) m_alarm[i] = n_alarm[i];
    if (!SIM_RST) model_clear();
    @(negedge SIM_CLK);
  endtask

  task automatic lit(input string name, input logic [16:1] exp);
    #1;
    check(name, {1'b0, mdt}, {1'b0, exp});
  endtask

  task automatic idle();
    MT01 = 0; MT05 = 0; MT12 = 0; MRCH = 0; MWCH = 0; MWSG = 0; wl = '0;
    MPAL_n = 1; MTCAL_n = 1; MRPTAL_n = 1; MWATCH_n = 1;
    MVFAIL_n = 1; MCTRAL_n = 1; MSCAFL_n = 1; MSCDBL_n = 1;
  endtask

  task automatic select_chan(input logic [5:0] c);
    wl = c; MWSG = 1; MT01 = 1;
    step();
    MWSG = 0; MT01 = 0; wl = '0;
  endtask

  initial begin
    GND = 0; p4VSW = 1; SIM_RST = 0;
    idle();
    model_clear();
    #1;
    check("reset_mdt", {1'b0, mdt}, 17'h0);
    check("reset_misc", misc, 17'h0);
    @(negedge SIM_CLK);
    step();
    SIM_RST = 1;

    // reset then read channel 77
    select_chan(6'o77);
    MRCH = 1; lit("read77_after_reset", 16'h0000); step(); MRCH = 0;

    // TC trap pulse
    MTCAL_n = 0; step(); MTCAL_n = 1;
    MRCH = 1; lit("tcal_only", 16'h0004); step(); MRCH = 0;

    // clear, then parity + watchman, then clearing write
    MWCH = 1; MT05 = 1; step(); MWCH = 0; MT05 = 0;
    MPAL_n = 0; MWATCH_n = 0; step(); MPAL_n = 1; MWATCH_n = 1;
    MRCH = 1; lit("pal_watch", 16'h0011); step(); MRCH = 0;
    MWCH = 1; MT05 = 1; step(); MWCH = 0; MT05 = 0;
    MRCH = 1; lit("after_clear", 16'h0000); step(); MRCH = 0;

    // rupt lock held through the clearing write
    MRPTAL_n = 0; MPAL_n = 0; step(); MPAL_n = 1;
    MWCH = 1; MT05 = 1; step(); MWCH = 0; MT05 = 0; MRPTAL_n = 1;
    MRCH = 1; lit("set_beats_clear", 16'h0008); step(); MRCH = 0;

    // wrong channel hides latched alarms
    select_chan(6'o76);
    MRCH = 1; lit("chan76", 16'h0000); step(); MRCH = 0;
    select_chan(6'o77);
    MRCH = 1; lit("chan77_again", 16'h0008); step(); MRCH = 0;

    // power drop clears everything
    p4VSW = 0; MRCH = 1; lit("unpowered_read", 16'h0000); step(); p4VSW = 1; MRCH = 0;
    select_chan(6'o77);
    MRCH = 1; lit("after_power", 16'h0000); step(); MRCH = 0;

    // scaler alarms
    MSCDBL_n = 0; MSCAFL_n = 0; step(); MSCDBL_n = 1; MSCAFL_n = 1;
    MRCH = 1; lit("scaler", scaler_en() ? 16'h0180 : 16'h0000); step(); MRCH = 0;

    // reset in the middle of a read
    MWCH = 1; MT05 = 1; step(); MWCH = 0; MT05 = 0;
    MTCAL_n = 0; step(); MTCAL_n = 1;
    MRCH = 1; lit("pre_reset_read", 16'h0004);
    SIM_RST = 0; lit("reset_mid_read", 16'h0000);
    step();
    SIM_RST = 1; MRCH = 0;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      SIM_RST  = ($urandom_range(0, 99) != 0);
      p4VSW    = ($urandom_range(0, 39) != 0);
      MWSG     = ($urandom_range(0, 5) == 0);
      MT01     = ($urandom_range(0, 2) == 0);
      MT05     = ($urandom_range(0, 2) == 0);
      MT12     = ($urandom_range(0, 9) == 0);
      MWCH     = ($urandom_range(0, 5) == 0);
      MRCH     = ($urandom_range(0, 1) == 0);
      wl       = ($urandom_range(0, 1) == 0) ? 6'o77 : 6'($urandom_range(0, 63));
      MPAL_n   = ($urandom_range(0, 11) != 0);
      MTCAL_n  = ($urandom_range(0, 11) != 0);
      MRPTAL_n = ($urandom_range(0, 11) != 0);
      MWATCH_n = ($urandom_range(0, 11) != 0);
      MVFAIL_n = ($urandom_range(0, 11) != 0);
      MCTRAL_n = ($urandom_range(0, 11) != 0);
      MSCAFL_n = ($urandom_range(0, 11) != 0);
      MSCDBL_n = ($urandom_range(0, 11) != 0);
      GND      = 1'($urandom_range(0, 1));
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ch77_alarm_box.md
CH77_ALARM_BOX -- requirements
Module: ch77_alarm_box

Interface
REQ-001 SHALL have these ports, in this order; single clock; reset asynchronous, active-low.
- SIM_RST  in  1  asynchronous active-low reset
- SIM_CLK  in  1  sole clock, rising-edge
- p4VSW  in  1  switched supply; low = unpowered
- GND  in  1  ground reference; functionally unused
- Then interleaved pairs: MDT01 out, MT01 in; MDT02 out, MT05 in; MDT03 out, MT12 in.
- Then MDT04..MDT09 out, each followed by MWL01..MWL06 in respectively.
- Then MDT10 out, MRCH in; MDT11 out, MWCH in; MDT12 out, MWSG in; MDT13 out, MPAL_n in; MDT14 out, MTCAL_n in; MDT15 out, MRPTAL_n in; MDT16 out, MWATCH_n in.
- Then MNHSBF out, MVFAIL_n in; MNHNC out, MCTRAL_n in; MNHRPT out, MSCAFL_n in; MTCSAI out, MSCDBL_n in.
- Then outputs MSTRT, MAMU, MSTP, MSBSTP, MRDCH, MLDCH, MONPAR, MONWBK, MLOAD, MREAD, NHALGA, DOSCAL, DBLTST.
- All ports are 1 bit.
REQ-002 MDT01..MDT16 SHALL be the monitor data bus returned to the AGC; MT01/MT05/MT12 are timepulses; MWL01..06 are write-bus bits 1-6; MRCH/MWCH are read/write-channel strobes; MWSG is the write-S strobe.
REQ-003 Alarm inputs (all active-low) SHALL be: MPAL_n parity, MTCAL_n TC trap, MRPTAL_n rupt lock, MWATCH_n night watchman, MVFAIL_n voltage fail, MCTRAL_n counter fail, MSCAFL_n scaler fail, MSCDBL_n scaler double.

Function
REQ-004 Channel address register (6 bits) SHALL load MWL06..MWL01 on a SIM_CLK edge where MWSG=1 and MT01=1.
REQ-005 SEL SHALL be 1 while the address register equals octal 77; the address register SHALL clear to 0 on an edge where MT12=1 and MWSG=0.
REQ-006 Alarm latch (9 bits) SHALL set bits on an edge where the corresponding input is 0:
- bit1 PAL, bit2 reserved (always 0), bit3 TCAL, bit4 RPTAL, bit5 WATCH, bit6 VFAIL, bit7 CTRAL, bit8 SCAFL, bit9 SCDBL.
REQ-007 Latch SHALL clear entirely on an edge where SEL=1, MWCH=1 and MT05=1.
REQ-008 If set and clear coincide on one edge, set SHALL win for that bit.
REQ-009 MDT01..MDT09 SHALL combinationally equal the latch bits while SEL=1 and MRCH=1; otherwise 0.
REQ-010 MDT10..MDT16 SHALL always be 0.
REQ-011 All other outputs (MNHSBF, MNHNC, MNHRPT, MTCSAI, MSTRT, MAMU, MSTP, MSBSTP, MRDCH, MLDCH, MONPAR, MONWBK, MLOAD, MREAD, NHALGA, DOSCAL, DBLTST) SHALL be constant 0.
REQ-012 While p4VSW=0: all outputs SHALL be 0; latch and address register SHALL be held clear synchronously.
REQ-013 Latency: alarm visible on MDT one SIM_CLK edge after the input goes low; read path has zero latency.

Reset
REQ-014 SIM_RST=0 SHALL asynchronously clear the latch and address register; all outputs read 0 during reset.
REQ-015 Reset release SHALL take effect on the next SIM_CLK edge; reset mid-read SHALL drop MDT to 0 immediately.

Configuration
REQ-016 With CH77_SCALER_ALARMS_EN defined, bits 8-9 SHALL follow REQ-006.
REQ-017 Without CH77_SCALER_ALARMS_EN, bits 8-9 SHALL never set, MDT08/MDT09 SHALL read 0, and MSCAFL_n/MSCDBL_n SHALL be ignored.

Verification
REQ-018 The bench SHALL cover these scenarios:
- Reset then read channel 77: MWL=77o with MWSG+MT01, MRCH=1 -> MDT01..16 all 0.
- MTCAL_n low one cycle, then read 77 -> MDT03=1, all other MDT bits 0.
- MPAL_n + MWATCH_n pulsed, then write 77 (MWCH+MT05), then read -> 0, and MDT01/MDT05=1 before the write.
- MRPTAL_n held low during the clearing write -> MDT04 remains 1.
- Read with address 76o -> MDT all 0 despite latched alarms.
- Alarm latched, then p4VSW=0 for one cycle, then read -> 0; with macro undefined, MSCDBL_n low -> MDT09=0.
